// File: rtl/cmpy_pkg.sv
// Shared widths, tdata field offsets and sign-extension helper
// for the complex-multiplier output accumulator.
package cmpy_pkg;

    localparam int IN_W_DEF  = 40;
    localparam int ACC_W_DEF = 48;
    localparam int LEN_DEF   = 16;

    localparam int REAL_LSB = 0;
    localparam int IMAG_LSB = IN_W_DEF;

    // Wide scratch width; callers size-cast the result down to ACC_W.
    localparam int SX_W = 128;

    function automatic logic [SX_W-1:0] sext(
        input logic [SX_W-1:0] x,
        input int              w
    );
        logic [SX_W-1:0] r;
        r = '0;
        for (int i = 0; i < SX_W; i++)
            r[i] = (i < w) ? x[i] : x[w-1];
        return r;
    endfunction

endpackage

// File: rtl/cmpy_acc_lane.sv
// One signed accumulator component with sticky overflow detection.
// o_sum/o_ovf present this beat's result before it is registered.
module cmpy_acc_lane
    import cmpy_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_add,
    input  logic             i_clr,
    input  logic [ACC_W-1:0] i_din,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_ovf
);

    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic             w_ovf;

    assign o_sum = r_acc + i_din;
    assign w_ovf = (r_acc[ACC_W-1] == i_din[ACC_W-1]) &&
                   (o_sum[ACC_W-1] != r_acc[ACC_W-1]);
    assign o_ovf = r_ovf | w_ovf;

    // The block-completing beat hands its result out and restarts at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (i_add) begin
            if (i_clr) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
            end else begin
                r_acc <= o_sum;
                r_ovf <= o_ovf;
            end
        end
    end

endmodule

// File: rtl/cmpy_dout_acc.sv
// Block accumulator for the complex multiplier product stream with a
// one-entry output register so the next block overlaps a stalled result.
module cmpy_dout_acc
    import cmpy_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN   = LEN_DEF
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               aclken,
    input  logic               s_axis_dout_tvalid,
    output logic               s_axis_dout_tready,
    input  logic [2*IN_W-1:0]  s_axis_dout_tdata,
    output logic               m_axis_acc_tvalid,
    input  logic               m_axis_acc_tready,
    output logic [2*ACC_W-1:0] m_axis_acc_tdata,
    output logic [1:0]         m_axis_acc_tuser
);

    localparam logic [15:0] LAST = 16'(LEN - 1);

    logic [15:0]        r_cnt;
    logic               r_vld;
    logic [2*ACC_W-1:0] r_data;
    logic [1:0]         r_user;

    logic               w_last;
    logic               w_beat;
    logic [IN_W-1:0]    w_in_re;
    logic [IN_W-1:0]    w_in_im;
    logic [ACC_W-1:0]   w_sx_re;
    logic [ACC_W-1:0]   w_sx_im;
    logic [ACC_W-1:0]   w_sum_re;
    logic [ACC_W-1:0]   w_sum_im;
    logic               w_ovf_re;
    logic               w_ovf_im;

    assign w_last = (r_cnt == LAST);

    // Only the completing beat waits, and only behind an undelivered sum.
    assign s_axis_dout_tready = aclken & ~areset &
                                ~(w_last & r_vld & ~m_axis_acc_tready);

    assign w_beat = aclken & s_axis_dout_tvalid & s_axis_dout_tready;

    assign w_in_re = s_axis_dout_tdata[REAL_LSB +: IN_W];
    assign w_in_im = s_axis_dout_tdata[IN_W +: IN_W];

    assign w_sx_re = ACC_W'(sext(SX_W'(w_in_re), IN_W));
    assign w_sx_im = ACC_W'(sext(SX_W'(w_in_im), IN_W));

    cmpy_acc_lane #(.ACC_W(ACC_W)) u_lane_re (
        .clk   (aclk),
        .rst   (areset),
        .i_add (w_beat),
        .i_clr (w_last),
        .i_din (w_sx_re),
        .o_sum (w_sum_re),
        .o_ovf (w_ovf_re)
    );

    cmpy_acc_lane #(.ACC_W(ACC_W)) u_lane_im (
        .clk   (aclk),
        .rst   (areset),
        .i_add (w_beat),
        .i_clr (w_last),
        .i_din (w_sx_im),
        .o_sum (w_sum_im),
        .o_ovf (w_ovf_im)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_cnt  <= '0;
            r_vld  <= 1'b0;
            r_data <= '0;
            r_user <= '0;
        end else if (aclken) begin
            if (w_beat)
                r_cnt <= w_last ? '0 : r_cnt + 16'd1;
            // A reload wins over a same-cycle delivery, keeping tvalid high.
            if (w_beat && w_last) begin
                r_vld  <= 1'b1;
                r_data <= {w_sum_im, w_sum_re};
                r_user <= {w_ovf_im, w_ovf_re};
            end else if (m_axis_acc_tready) begin
                r_vld <= 1'b0;
            end
        end
    end

    assign m_axis_acc_tvalid = r_vld;
    assign m_axis_acc_tdata  = r_data;
    assign m_axis_acc_tuser  = r_user;

endmodule

// File: tb/tb_cmpy_dout_acc.sv
// Self-checking bench for cmpy_dout_acc: directed scenarios plus a
// randomized handshake run against an integer-arithmetic reference model.
module tb_cmpy_dout_acc;

    localparam int IN_W  = 40;
    localparam int ACC_W = 41;
    localparam int LEN   = 4;
    localparam int OW    = 2 + 2*ACC_W;

    logic               aclk;
    logic               areset;
    logic               aclken;
    logic               s_tvalid;
    logic               s_tready;
    logic [2*IN_W-1:0]  s_tdata;
    logic               m_tvalid;
    logic               m_tready;
    logic [2*ACC_W-1:0] m_tdata;
    logic [1:0]         m_tuser;

    int n_tests = 0;
    int n_fail  = 0;

    longint           in_re[$];
    longint           in_im[$];
    logic [OW-1:0]    exp_q[$];
    logic [OW-1:0]    out_q[$];

    cmpy_dout_acc #(.IN_W(IN_W), .ACC_W(ACC_W), .LEN(LEN)) dut (
        .aclk               (aclk),
        .areset             (areset),
        .aclken             (aclken),
        .s_axis_dout_tvalid (s_tvalid),
        .s_axis_dout_tready (s_tready),
        .s_axis_dout_tdata  (s_tdata),
        .m_axis_acc_tvalid  (m_tvalid),
        .m_axis_acc_tready  (m_tready),
        .m_axis_acc_tdata   (m_tdata),
        .m_axis_acc_tuser   (m_tuser)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Output handshakes complete at the following rising edge.
    always @(negedge aclk)
        if (!areset && aclken && m_tvalid && m_tready)
            out_q.push_back({m_tuser, m_tdata});

    function automatic longint rnd40();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return longint'($signed(t[IN_W-1:0]));
    endfunction

    // True-integer add, flag if it leaves the ACC_W range, then wrap.
    task automatic step(inout longint a, inout bit f, input longint x);
        longint half;
        longint t;
        half = longint'(1) <<< (ACC_W - 1);
        t = a + x;
        if (t >= half || t < -half) f = 1'b1;
        if (t >= half) t = t - 2*half;
        if (t < -half) t = t + 2*half;
        a = t;
    endtask

    task automatic build_expected();
        longint ar, ai;
        bit     fr, fi;
        int     k;
        exp_q.delete();
        ar = 0; ai = 0; fr = 0; fi = 0; k = 0;
        for (int i = 0; i < in_re.size(); i++) begin
            step(ar, fr, in_re[i]);
            step(ai, fi, in_im[i]);
            k++;
            if (k == LEN) begin
                exp_q.push_back({fi, fr, ACC_W'(ai), ACC_W'(ar)});
                ar = 0; ai = 0; fr = 0; fi = 0; k = 0;
            end
        end
    endtask

    task automatic clear_all();
        in_re.delete();
        in_im.delete();
        out_q.delete();
        exp_q.delete();
    endtask

    task automatic add_beat(input longint re, input longint im);
        in_re.push_back(re);
        in_im.push_back(im);
    endtask

    // Present beats lo..hi-1 in order; each is held until accepted.
    task automatic send_range(input int lo, input int hi,
                              input int vpct, input bit rrand);
        int i;
        int guard;
        i = lo;
        guard = 0;
        while (i < hi && guard < 20000) begin
            s_tvalid = ($urandom_range(0, 99) < vpct);
            s_tdata  = {in_im[i][IN_W-1:0], in_re[i][IN_W-1:0]};
            if (rrand) m_tready = $urandom_range(0, 1);
            @(negedge aclk);
            if (s_tvalid && s_tready && aclken) i++;
            @(posedge aclk); #1;
            guard++;
        end
        s_tvalid = 1'b0;
        if (rrand) m_tready = 1'b1;
        if (i < hi) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: sent %0d of %0d beats", i - lo, hi - lo);
        end
    endtask

    task automatic drain(input int n);
        m_tready = 1'b1;
        repeat (n) begin
            @(posedge aclk); #1;
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        @(negedge aclk);
        n_tests++;
        if ({s_tready, m_tvalid, m_tdata, m_tuser} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: tready=%b tvalid=%b tdata=%h tuser=%b required all 0",
                     s_tready, m_tvalid, m_tdata, m_tuser);
        end
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        n_tests++;
        if (s_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_tready: got %b required 1", s_tready);
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_basic();
        clear_all();
        add_beat(11, 2);
        add_beat(-110000, -20000);
        add_beat(0, 50);
        add_beat(1, 0);
        m_tready = 1'b1;
        send_range(0, 4, 100, 1'b0);
        n_tests++;
        if (m_tvalid !== 1'b1 || m_tuser !== 2'b00 ||
            m_tdata !== {ACC_W'(-19948), ACC_W'(-109988)}) begin
            n_fail++;
            $display("FAIL basic_latency: tvalid=%b tuser=%b tdata=%h required 1/00/(-109988,-19948)",
                     m_tvalid, m_tuser, m_tdata);
        end
        drain(4);
        n_tests++;
        if (out_q.size() != 1 || m_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_count: got %0d outputs tvalid=%b required 1 output tvalid=0",
                     out_q.size(), m_tvalid);
        end
    endtask

    task automatic test_overflow();
        longint big;
        clear_all();
        big = (longint'(1) <<< 39) - 1;
        for (int i = 0; i < 4; i++) add_beat(big, 0);
        for (int i = 0; i < 4; i++) add_beat(0, 0);
        build_expected();
        send_range(0, 8, 100, 1'b0);
        drain(4);
        n_tests++;
        if (out_q.size() != 2) begin
            n_fail++;
            $display("FAIL ovf_count: got %0d required 2", out_q.size());
        end else begin
            n_tests++;
            if (out_q[0] !== {2'b01, ACC_W'(0), ACC_W'(-4)} || out_q[0] !== exp_q[0]) begin
                n_fail++;
                $display("FAIL ovf_wrap: got %h required %h", out_q[0], exp_q[0]);
            end
            n_tests++;
            if (out_q[1] !== '0) begin
                n_fail++;
                $display("FAIL ovf_clear: got %h required 0", out_q[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        clear_all();
        for (int i = 0; i < 8; i++) add_beat(rnd40(), rnd40());
        build_expected();
        m_tready = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 7; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = {in_im[i][IN_W-1:0], in_re[i][IN_W-1:0]};
            @(negedge aclk);
            if (s_tready !== 1'b1) ok = 1'b0;
            @(posedge aclk); #1;
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bp_first7: some of the first 7 beats stalled, required all accepted");
        end
        s_tdata = {in_im[7][IN_W-1:0], in_re[7][IN_W-1:0]};
        repeat (4) begin
            @(negedge aclk);
            n_tests++;
            if (s_tready !== 1'b0 || m_tvalid !== 1'b1 ||
                {m_tuser, m_tdata} !== exp_q[0]) begin
                n_fail++;
                $display("FAIL bp_stall: tready=%b tvalid=%b out=%h required 0/1/%h",
                         s_tready, m_tvalid, {m_tuser, m_tdata}, exp_q[0]);
            end
            @(posedge aclk); #1;
        end
        m_tready = 1'b1;
        @(negedge aclk);
        n_tests++;
        if (s_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_tready: got %b required 1", s_tready);
        end
        @(posedge aclk); #1;
        s_tvalid = 1'b0;
        n_tests++;
        if (m_tvalid !== 1'b1 || {m_tuser, m_tdata} !== exp_q[1]) begin
            n_fail++;
            $display("FAIL bp_reload: tvalid=%b out=%h required 1/%h",
                     m_tvalid, {m_tuser, m_tdata}, exp_q[1]);
        end
        drain(3);
        n_tests++;
        if (out_q.size() != 2 || out_q[0] !== exp_q[0] || out_q[1] !== exp_q[1]) begin
            n_fail++;
            $display("FAIL bp_order: got %0d outputs required 2 in order", out_q.size());
        end
    endtask

    task automatic test_clken();
        clear_all();
        for (int i = 0; i < 8; i++) add_beat(rnd40(), rnd40());
        build_expected();
        m_tready = 1'b0;
        send_range(0, 6, 100, 1'b0);
        s_tvalid = 1'b1;
        s_tdata  = {in_im[6][IN_W-1:0], in_re[6][IN_W-1:0]};
        aclken   = 1'b0;
        m_tready = 1'b1;
        repeat (5) begin
            @(negedge aclk);
            n_tests++;
            if (s_tready !== 1'b0 || m_tvalid !== 1'b1 ||
                {m_tuser, m_tdata} !== exp_q[0]) begin
                n_fail++;
                $display("FAIL clken_freeze: tready=%b tvalid=%b out=%h required 0/1/%h",
                         s_tready, m_tvalid, {m_tuser, m_tdata}, exp_q[0]);
            end
            @(posedge aclk); #1;
        end
        aclken = 1'b1;
        send_range(6, 8, 100, 1'b0);
        drain(4);
        n_tests++;
        if (out_q.size() != 2 || out_q[0] !== exp_q[0] || out_q[1] !== exp_q[1]) begin
            n_fail++;
            $display("FAIL clken_result: got %0d outputs last=%h required 2 last=%h",
                     out_q.size(), out_q.size() > 0 ? out_q[out_q.size()-1] : '0, exp_q[1]);
        end
    endtask

    task automatic test_midreset();
        clear_all();
        for (int i = 0; i < 6; i++) add_beat(rnd40(), rnd40());
        m_tready = 1'b0;
        send_range(0, 6, 100, 1'b0);
        areset = 1'b1;
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        areset = 1'b0;
        m_tready = 1'b1;
        clear_all();
        for (int i = 0; i < 4; i++) add_beat(1, 1);
        send_range(0, 4, 100, 1'b0);
        drain(4);
        n_tests++;
        if (out_q.size() != 1 || out_q[0] !== {2'b00, ACC_W'(4), ACC_W'(4)}) begin
            n_fail++;
            $display("FAIL midreset: got %0d outputs first=%h required 1 of (4,4)",
                     out_q.size(), out_q.size() > 0 ? out_q[0] : '0);
        end
    endtask

    task automatic test_random();
        int bad;
        clear_all();
        for (int i = 0; i < 1000; i++) add_beat(rnd40(), rnd40());
        build_expected();
        send_range(0, 1000, 50, 1'b1);
        drain(6);
        n_tests++;
        if (out_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count: got %0d required %0d", out_q.size(), exp_q.size());
        end
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            n_tests++;
            if (out_q[i] !== exp_q[i]) begin
                n_fail++;
                if (bad < 5)
                    $display("FAIL rand_sum[%0d]: got %h required %h", i, out_q[i], exp_q[i]);
                bad++;
            end
        end
    endtask

    initial begin
        areset   = 1'b1;
        aclken   = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b1;
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_clken();
        test_midreset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
